// File: rtl/river_raid_pkg.sv
// river_raid_pkg: shared state type, register map and reset constants for the frame commit block
package river_raid_pkg;
  typedef enum logic [1:0] {IDLE, DIRTY, ARMED, COMMIT} state_t;
  localparam logic [2:0] ADDR_R    = 3'd0;
  localparam logic [2:0] ADDR_G    = 3'd1;
  localparam logic [2:0] ADDR_B    = 3'd2;
  localparam logic [2:0] ADDR_HS   = 3'd3;
  localparam logic [2:0] ADDR_HE   = 3'd4;
  localparam logic [2:0] ADDR_VS   = 3'd5;
  localparam logic [2:0] ADDR_VE   = 3'd6;
  localparam logic [2:0] ADDR_CTRL = 3'd7;
  localparam int SCALE = 5;
  localparam logic [9:0] VBLANK_LINE = 10'd480;
  localparam logic [7:0] RST_R = 8'h00;
  localparam logic [7:0] RST_G = 8'h00;
  localparam logic [7:0] RST_B = 8'h80;
  function automatic logic [10:0] scale(input logic [7:0] v);
    return {3'b000, v} * 11'(SCALE);
  endfunction
endpackage

// File: rtl/vblank_detect.sv
// vblank_detect: flags the first pixel of the vertical blanking line
module vblank_detect
  import river_raid_pkg::*;
(
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        frame_start
);
  assign frame_start = (vcount == VBLANK_LINE) && (hcount == 11'd0);
endmodule

// File: rtl/frame_commit_ctrl.sv
// frame_commit_ctrl: shadow display registers committed atomically at vblank (FRAME_COMMIT_AUTO_EN: dirty shadow commits without request)
module frame_commit_ctrl
  import river_raid_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [7:0]  bg_r,
  output logic [7:0]  bg_g,
  output logic [7:0]  bg_b,
  output logic [10:0] h_start,
  output logic [10:0] h_end,
  output logic [10:0] v_start,
  output logic [10:0] v_end,
  output logic        commit_ack,
  output logic        pending,
  output logic        err,
  output logic [15:0] frame_count
);
`ifdef FRAME_COMMIT_AUTO_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif
  state_t state, nxt;
  logic [7:0] sh_r, sh_g, sh_b, rd_val;
  logic [10:0] sh_hs, sh_he, sh_vs, sh_ve;
  logic frame_start, ack_seen, sh_wr, ctl, commit_req, cancel, clr_err, rd_ctl, bad;
  vblank_detect u_vblank (.hcount(hcount), .vcount(vcount), .frame_start(frame_start));
  assign sh_wr      = chipselect && write && address != ADDR_CTRL;
  assign ctl        = chipselect && write && address == ADDR_CTRL;
  assign cancel     = ctl && writedata[2];
  assign commit_req = ctl && writedata[0] && !writedata[2];
  assign clr_err    = ctl && writedata[1];
  assign rd_ctl     = chipselect && read && address == ADDR_CTRL;
  assign bad        = (sh_hs > sh_he) || (sh_vs > sh_ve);
  assign pending    = state == DIRTY || state == ARMED;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = commit_req ? ARMED : sh_wr ? DIRTY : IDLE;
      DIRTY:   nxt = (AUTO && frame_start) ? COMMIT : commit_req ? ARMED : DIRTY;
      ARMED:   nxt = cancel ? DIRTY : frame_start ? COMMIT : ARMED;
      default: nxt = sh_wr ? DIRTY : IDLE;
    endcase
  end
  always_comb begin
    rd_val = {4'b0000, state == ARMED, pending, err, ack_seen};
    case (address)
      ADDR_R:  rd_val = sh_r;
      ADDR_G:  rd_val = sh_g;
      ADDR_B:  rd_val = sh_b;
      ADDR_HS: rd_val = sh_hs[7:0];
      ADDR_HE: rd_val = sh_he[7:0];
      ADDR_VS: rd_val = sh_vs[7:0];
      ADDR_VE: rd_val = sh_ve[7:0];
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sh_r <= RST_R;
      sh_g <= RST_G;
      sh_b <= RST_B;
      sh_hs <= '0;
      sh_he <= '0;
      sh_vs <= '0;
      sh_ve <= '0;
    end else begin
      state <= nxt;
      if (sh_wr && address == ADDR_R) sh_r <= writedata;
      if (sh_wr && address == ADDR_G) sh_g <= writedata;
      if (sh_wr && address == ADDR_B) sh_b <= writedata;
      if (sh_wr && address == ADDR_HS) sh_hs <= scale(writedata);
      if (sh_wr && address == ADDR_HE) sh_he <= scale(writedata);
      if (sh_wr && address == ADDR_VS) sh_vs <= scale(writedata);
      if (sh_wr && address == ADDR_VE) sh_ve <= scale(writedata);
    end
  end
  // committed copy samples the shadow before any same-cycle write lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bg_r <= RST_R;
      bg_g <= RST_G;
      bg_b <= RST_B;
      h_start <= '0;
      h_end <= '0;
      v_start <= '0;
      v_end <= '0;
      commit_ack <= 1'b0;
      err <= 1'b0;
      ack_seen <= 1'b0;
      frame_count <= '0;
      readdata <= '0;
    end else begin
      if (state == COMMIT) begin
        bg_r <= sh_r;
        bg_g <= sh_g;
        bg_b <= sh_b;
        if (!bad) begin
          h_start <= sh_hs;
          h_end <= sh_he;
          v_start <= sh_vs;
          v_end <= sh_ve;
        end
      end
      commit_ack <= state == COMMIT;
      err <= (state == COMMIT && bad) || (err && !clr_err);
      ack_seen <= commit_ack || (ack_seen && !rd_ctl);
      frame_count <= frame_count + 16'(frame_start);
      if (chipselect && read) readdata <= rd_val;
    end
  end
endmodule

// File: doc/frame_commit_ctrl.md
FRAME_COMMIT_CTRL -- requirements
Module: frame_commit_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, 50 MHz.
REQ-002 SHALL have: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: chipselect  in  1, write  in  1, read  in  1, address  in  3, writedata  in  8  (Avalon slave).
REQ-004 SHALL have: readdata  out  8  (status readback).
REQ-005 SHALL have: hcount  in  11, vcount  in  10  (raster position from VGA counters).
REQ-006 SHALL have: bg_r, bg_g, bg_b  out  8 each  (committed background colour).
REQ-007 SHALL have: h_start, h_end, v_start, v_end  out  11 each  (committed sprite bounds, pixel units).
REQ-008 SHALL have: commit_ack  out  1  (one-cycle pulse), pending  out  1, err  out  1  (sticky), frame_count  out  16.

Function
REQ-009 SHALL hold a shadow copy of all seven registers; Avalon writes (chipselect && write) update only the shadow copy: addr 0-2 colour, addr 3-6 bounds = writedata*5 (11-bit, max 1275, no overflow).
REQ-010 SHALL decode addr 7 write as control: bit0 commit request, bit1 clear err, bit2 cancel request.
REQ-011 SHALL generate frame_start for one cycle when vcount==480 && hcount==0.
REQ-012 SHALL implement FSM IDLE (shadow clean), DIRTY (shadow written), ARMED (commit requested), COMMIT (one cycle).
REQ-013 Transitions: IDLE->DIRTY on shadow write; IDLE/DIRTY->ARMED on commit request; ARMED->DIRTY on cancel; ARMED->COMMIT on frame_start; COMMIT->IDLE, or ->DIRTY if a shadow write occurred in the COMMIT cycle.
REQ-014 In COMMIT, outputs SHALL load all seven shadow values atomically in one cycle; commit_ack SHALL pulse in the following cycle.
REQ-015 If shadow h_start>h_end or v_start>v_end at COMMIT, the four bound outputs SHALL keep their previous values, colours SHALL still update, and err SHALL set.
REQ-016 A shadow write in the same cycle as COMMIT SHALL be excluded from this commit and remain pending.
REQ-017 Commit request and cancel in the same write: cancel wins. Commit request in ARMED: no effect.
REQ-018 pending SHALL be 1 in DIRTY and ARMED, else 0.
REQ-019 frame_count SHALL increment on every frame_start and wrap 0xFFFF->0.
REQ-020 readdata SHALL be {4'b0, state==ARMED, pending, err, commit_ack_seen}, registered, valid one cycle after read to addr 7; other addresses SHALL return shadow[7:0] of that register (bounds: low 8 bits of scaled value).
REQ-021 commit_ack_seen SHALL set on commit_ack and clear on a read of addr 7.

Reset
REQ-022 On reset_n low, immediately: state IDLE; shadow and committed bg = 00/00/80; all bounds 0; commit_ack 0, err 0, frame_count 0, readdata 0, commit_ack_seen 0.
REQ-023 Reset asserted mid-ARMED or COMMIT SHALL abandon the commit with no partial update visible after release.

Configuration
REQ-024 Macro FRAME_COMMIT_AUTO_EN: when defined, DIRTY SHALL also go to COMMIT on frame_start without a commit request; when undefined, commit occurs only from ARMED.

Structure
REQ-025 Package river_raid_pkg SHALL hold the state enum, address constants (0-7), SCALE=5, VBLANK_LINE=480, reset colour constants.
REQ-026 Sub-module vblank_detect SHALL produce frame_start from hcount/vcount.

Verification
REQ-027 Reset release -> bg 00/00/80, bounds 0, state IDLE, frame_count 0.
REQ-028 Write addr3=10, addr4=20 -> h_start/h_end stay 0, pending=1; write addr7=0x01, next frame_start -> h_start=50, h_end=100, commit_ack pulses once.
REQ-029 Shadow addr3=40, addr4=20, commit -> bounds unchanged, err=1; write addr7=0x02 -> err=0.
REQ-030 Shadow write addr0=FF in the COMMIT cycle -> bg_r not FF after this commit, state DIRTY, applied at the next commit.
REQ-031 Arm, then write addr7=0x04 before frame_start -> no commit, state DIRTY; with FRAME_COMMIT_AUTO_EN, commit at the next frame_start.
REQ-032 Run 65536 frames -> frame_count wraps to 0; reset_n pulse while ARMED -> outputs return to reset values.
